// File: rtl/piano_keyboard_renderer_if.sv
// Pixel-stream bundle between the VGA timing side and the keyboard renderer.
// Carries scan position, key masks, and the rendered colour and frame tick.
// One pixel per clock; there is no backpressure on this path.
interface piano_keyboard_renderer_if #(
   parameter int NK = 13
) ();
   logic          bright;
   logic [9:0]    hCount;
   logic [9:0]    vCount;
   logic [NK-1:0] pressedKeys;
   logic [NK-1:0] targetKeys;
   logic          showTarget;
   logic [11:0]   rgb;
   logic          frameTick;

   modport master (
      output bright, hCount, vCount, pressedKeys, targetKeys, showTarget,
      input  rgb, frameTick
   );

   modport slave (
      input  bright, hCount, vCount, pressedKeys, targetKeys, showTarget,
      output rgb, frameTick
   );
endinterface

// File: rtl/piano_keyboard_renderer.sv
// Purpose: draws a piano keyboard and colours keys by pressed vs target chord.
// Latency: rgb follows hCount/vCount/bright by 2 clocks; frameTick 1 clock after frame start.
// Backpressure: none, one pixel accepted and produced every clock.
module piano_keyboard_renderer #(
   parameter int NUM_OCTAVES  = 1,
   parameter int WHITE_KEY_W  = 45,
   parameter int WHITE_KEY_H  = 180,
   parameter int BLACK_KEY_W  = 25,
   parameter int BLACK_KEY_H  = 110,
   parameter int KEY_GAP      = 2,
   parameter int ORIGIN_X     = 220,
   parameter int ORIGIN_Y     = 200,
   parameter int BLINK_FRAMES = 16
) (
   input logic clk,
   input logic reset,
   piano_keyboard_renderer_if.slave vga
);
   localparam int NK    = 12 * NUM_OCTAVES + 1;
   localparam int NW    = 7 * NUM_OCTAVES + 1;
   localparam int NB    = 5 * NUM_OCTAVES;
   localparam int KW    = $clog2(NK);
   localparam int PITCH = WHITE_KEY_W + KEY_GAP;
   localparam int BCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   // Chromatic number of white key w (C D E F G A B within each octave).
   function automatic int whiteChrom(input int w);
      int off;
      case (w % 7)
         0:       off = 0;
         1:       off = 2;
         2:       off = 4;
         3:       off = 5;
         4:       off = 7;
         5:       off = 9;
         default: off = 11;
      endcase
      return 12 * (w / 7) + off;
   endfunction

   // White key that black key b sits to the right of (after C D F G A).
   function automatic int blackLeftWhite(input int b);
      int pos;
      case (b % 5)
         0:       pos = 0;
         1:       pos = 1;
         2:       pos = 3;
         3:       pos = 4;
         default: pos = 5;
      endcase
      return 7 * (b / 5) + pos;
   endfunction

   // Chromatic number of black key b (1 3 6 8 10 within each octave).
   function automatic int blackChrom(input int b);
      int off;
      case (b % 5)
         0:       off = 1;
         1:       off = 3;
         2:       off = 6;
         3:       off = 8;
         default: off = 10;
      endcase
      return 12 * (b / 5) + off;
   endfunction

   function automatic logic [11:0] keyColour(input logic p, input logic t, input logic show,
                                             input logic phase, input logic isBlack);
      if (p && t)                  return 12'h6D6;
      else if (p && !t)            return 12'hE66;
      else if (t && show && phase) return 12'hBDF;
      else if (isBlack)            return 12'h000;
      else                         return 12'hFFF;
   endfunction

   logic [31:0]   xPos, yPos;
   logic          inWhiteRows, inBlackRows;
   logic [NW-1:0] whiteHit;
   logic [NB-1:0] blackHit;
   logic [KW-1:0] whiteCode [NW];
   logic [KW-1:0] blackCode [NB];
   logic          whiteVld, blackVld;
   logic [KW-1:0] whiteIdx, blackIdx;

   logic          s1Bright, s1WhtVld, s1BlkVld;
   logic [KW-1:0] s1WhtIdx, s1BlkIdx;

   logic          atOrigin, originSeen, frameStart;
   logic [NK-1:0] latPressed, latTarget;
   logic          latShow, blinkPhase;
   logic [BCW-1:0] blinkCnt;
   logic [11:0]   pixColour, rgbReg;
   logic          tickReg;

   assign xPos        = 32'(vga.hCount);
   assign yPos        = 32'(vga.vCount);
   assign inWhiteRows = (yPos >= 32'(ORIGIN_Y)) && (yPos < 32'(ORIGIN_Y + WHITE_KEY_H));
   assign inBlackRows = (yPos >= 32'(ORIGIN_Y)) && (yPos < 32'(ORIGIN_Y + BLACK_KEY_H));

   for (genvar i = 0; i < NW; i++) begin : gWhite
      localparam logic [31:0] X0 = 32'(ORIGIN_X + i * PITCH);
      assign whiteHit[i]  = inWhiteRows && (xPos >= X0) && (xPos < X0 + 32'(WHITE_KEY_W));
      assign whiteCode[i] = KW'(whiteChrom(i));
   end

   // The trailing C has no black key, so only NB = 5 per octave exist.
   for (genvar b = 0; b < NB; b++) begin : gBlack
      localparam logic [31:0] X0 =
         32'(ORIGIN_X + blackLeftWhite(b) * PITCH + WHITE_KEY_W - BLACK_KEY_W / 2);
      assign blackHit[b]  = inBlackRows && (xPos >= X0) && (xPos < X0 + 32'(BLACK_KEY_W));
      assign blackCode[b] = KW'(blackChrom(b));
   end

   // Encode the (at most one) white-key hit into its chromatic key number.
   always_comb begin
      whiteVld = 1'b0;
      whiteIdx = '0;
      for (int i = 0; i < NW; i++) begin
         if (whiteHit[i]) begin
            whiteVld = 1'b1;
            whiteIdx = whiteCode[i];
         end
      end
   end

   // Encode the (at most one) black-key hit into its chromatic key number.
   always_comb begin
      blackVld = 1'b0;
      blackIdx = '0;
      for (int b = 0; b < NB; b++) begin
         if (blackHit[b]) begin
            blackVld = 1'b1;
            blackIdx = blackCode[b];
         end
      end
   end

   // Stage 1: register geometry results for the current pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1Bright <= 1'b0;
         s1WhtVld <= 1'b0;
         s1WhtIdx <= '0;
         s1BlkVld <= 1'b0;
         s1BlkIdx <= '0;
      end else begin
         s1Bright <= vga.bright;
         s1WhtVld <= whiteVld;
         s1WhtIdx <= whiteIdx;
         s1BlkVld <= blackVld;
         s1BlkIdx <= blackIdx;
      end
   end

   // A frame starts only on the first cycle at (0,0), so a held origin counts once.
   assign atOrigin   = (vga.hCount == 10'd0) && (vga.vCount == 10'd0);
   assign frameStart = atOrigin && !originSeen;

   // Latch masks, pulse frameTick and step the blink counter once per frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         originSeen <= 1'b0;
         tickReg    <= 1'b0;
         latPressed <= '0;
         latTarget  <= '0;
         latShow    <= 1'b0;
         blinkCnt   <= '0;
         blinkPhase <= 1'b0;
      end else begin
         originSeen <= atOrigin;
         tickReg    <= frameStart;
         if (frameStart) begin
            latPressed <= vga.pressedKeys;
            latTarget  <= vga.targetKeys;
            latShow    <= vga.showTarget;
            if (blinkCnt == BCW'(BLINK_FRAMES - 1)) begin
               blinkCnt   <= '0;
               blinkPhase <= ~blinkPhase;
            end else begin
               blinkCnt <= blinkCnt + BCW'(1);
            end
         end
      end
   end

   // Pick the pixel colour: blanking, then black keys over white keys, then background.
   always_comb begin
      pixColour = 12'hCA9;
      if (!s1Bright) begin
         pixColour = 12'h000;
      end else if (s1BlkVld) begin
         pixColour = keyColour(latPressed[s1BlkIdx], latTarget[s1BlkIdx], latShow, blinkPhase, 1'b1);
      end else if (s1WhtVld) begin
         pixColour = keyColour(latPressed[s1WhtIdx], latTarget[s1WhtIdx], latShow, blinkPhase, 1'b0);
      end
   end

   // Stage 2: register the output colour.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rgbReg <= 12'h000;
      else       rgbReg <= pixColour;
   end

   assign vga.rgb       = rgbReg;
   assign vga.frameTick = tickReg;
endmodule
